// File: rtl/toivoh_serial_ram_reader_pkg.sv
// Shared defaults for the nibble-serial RAM reader.
// Frame geometry and ui_in control bit positions.
package toivoh_serial_ram_reader_pkg;

    localparam int RAM_PINS_DEF        = 4;
    localparam int RAM_LOG2_CYCLES_DEF = 2;
    localparam int RAM_READ_FRAMES_DEF = 2;

    localparam int CYC_DEF       = 2 ** RAM_LOG2_CYCLES_DEF;
    localparam int ADDR_BITS_DEF = RAM_PINS_DEF * CYC_DEF;
    localparam int WORD_BITS_DEF = ADDR_BITS_DEF;

    localparam int UI_HOLD     = 0;
    localparam int UI_CLEAR    = 1;
    localparam int UI_SEL_CSUM = 2;
    localparam int UI_SEL_HIGH = 3;

endpackage

// File: rtl/toivoh_serial_ram_reader_serial_ram_port.sv
// Serial RAM port: phase counter, address nibble mux, word
// deserializer and frame/valid tracking.
// Ports: clk, rst_n; addr in; data_nib in; addr_nib, phase,
// frame_end, word_reg (registered), word (incl. live nibble),
// word_strobe, word_valid out.
module serial_ram_port
    import toivoh_serial_ram_reader_pkg::*;
#(
    parameter int RAM_PINS        = RAM_PINS_DEF,
    parameter int RAM_LOG2_CYCLES = RAM_LOG2_CYCLES_DEF,
    parameter int RAM_READ_FRAMES = RAM_READ_FRAMES_DEF,
    localparam int CYC            = 2 ** RAM_LOG2_CYCLES,
    localparam int WORD_BITS      = RAM_PINS * CYC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORD_BITS-1:0]       addr,
    input  logic [RAM_PINS-1:0]        data_nib,
    output logic [RAM_PINS-1:0]        addr_nib,
    output logic [RAM_LOG2_CYCLES-1:0] phase,
    output logic                       frame_end,
    output logic [WORD_BITS-1:0]       word_reg,
    output logic [WORD_BITS-1:0]       word,
    output logic                       word_strobe,
    output logic                       word_valid
);

    localparam int FC_BITS = $clog2(RAM_READ_FRAMES + 1);
    localparam logic [RAM_LOG2_CYCLES-1:0] LAST =
        RAM_LOG2_CYCLES'(CYC - 1);
    localparam logic [FC_BITS-1:0] FC_MAX =
        FC_BITS'(RAM_READ_FRAMES);

    logic [FC_BITS-1:0] frame_cnt;

    assign frame_end   = (phase == LAST);
    assign word_strobe = frame_end && (frame_cnt == FC_MAX);
    assign addr_nib    = addr[RAM_PINS*phase +: RAM_PINS];

    // The word as it will be once this edge captures the
    // live nibble; only meaningful at the last phase.
    always_comb begin
        word = word_reg;
        word[RAM_PINS*phase +: RAM_PINS] = data_nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            word_reg   <= '0;
            frame_cnt  <= '0;
            word_valid <= 1'b0;
        end else begin
            phase <= phase + 1'b1;
            word_reg[RAM_PINS*phase +: RAM_PINS] <= data_nib;
            // Count saturates once read latency is covered.
            if (word_strobe) begin
                word_valid <= 1'b1;
            end else if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/toivoh_serial_ram_reader.sv
// Streams words from a nibble-serial RAM, keeps a running
// checksum and shows the word or checksum byte on uio_out.
// Ports: clk, rst_n, ena (ignored); ui_in = {data nibble,
// byte sel, csum sel, clear, hold}; uo_out = {addr nibble,
// 0, word_valid, phase}; uio_in unused; uio_out byte; uio_oe.
module toivoh_serial_ram_reader
    import toivoh_serial_ram_reader_pkg::*;
#(
    parameter int RAM_PINS        = RAM_PINS_DEF,
    parameter int RAM_LOG2_CYCLES = RAM_LOG2_CYCLES_DEF,
    parameter int RAM_READ_FRAMES = RAM_READ_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CYC       = 2 ** RAM_LOG2_CYCLES;
    localparam int ADDR_BITS = RAM_PINS * CYC;
    localparam int WORD_BITS = ADDR_BITS;

    logic [ADDR_BITS-1:0]       addr_q;
    logic [WORD_BITS-1:0]       csum_q;
    logic [WORD_BITS-1:0]       word_reg;
    logic [WORD_BITS-1:0]       word;
    logic [RAM_PINS-1:0]        addr_nib;
    logic [RAM_LOG2_CYCLES-1:0] phase;
    logic                       frame_end;
    logic                       word_strobe;
    logic                       word_valid;
    logic [15:0]                sel16;
    logic                       unused_inputs;

    assign unused_inputs = &{1'b0, ena, uio_in};

    serial_ram_port #(
        .RAM_PINS        (RAM_PINS),
        .RAM_LOG2_CYCLES (RAM_LOG2_CYCLES),
        .RAM_READ_FRAMES (RAM_READ_FRAMES)
    ) u_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr_q),
        .data_nib    (ui_in[7 -: RAM_PINS]),
        .addr_nib    (addr_nib),
        .phase       (phase),
        .frame_end   (frame_end),
        .word_reg    (word_reg),
        .word        (word),
        .word_strobe (word_strobe),
        .word_valid  (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            csum_q <= '0;
        end else begin
            // Address only moves between frames so it stays
            // stable while its nibbles are shifted out.
            if (frame_end && !ui_in[UI_HOLD]) begin
                addr_q <= addr_q + 1'b1;
            end
            if (ui_in[UI_CLEAR]) begin
                csum_q <= '0;
            end else if (word_strobe) begin
                csum_q <= csum_q + word;
            end
        end
    end

    always_comb begin
        sel16 = ui_in[UI_SEL_CSUM] ? 16'(csum_q)
                                   : 16'(word_reg);
        uio_out = ui_in[UI_SEL_HIGH] ? sel16[15:8]
                                     : sel16[7:0];
        uo_out = '0;
        uo_out[7 -: RAM_PINS] = addr_nib;
        uo_out[2]   = word_valid;
        uo_out[1:0] = 2'(phase);
    end

    assign uio_oe = 8'hFF;

endmodule

// File: tb/tb_toivoh_serial_ram_reader.sv
// Bench for toivoh_serial_ram_reader: random controls against
// a frame-level RAM/checksum model, plus an 8-bit wrap instance.
module tb_toivoh_serial_ram_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uo_out;
    logic [7:0] uio_in = '0;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       rst_n_b = 1'b0;
    logic [7:0] ui_in_b = '0;
    logic [7:0] uo_out_b;
    logic [7:0] uio_out_b;
    logic [7:0] uio_oe_b;

    always #5 clk = ~clk;

    toivoh_serial_ram_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    toivoh_serial_ram_reader #(
        .RAM_LOG2_CYCLES (1)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n_b),
        .ena     (ena),
        .ui_in   (ui_in_b),
        .uo_out  (uo_out_b),
        .uio_in  (uio_in),
        .uio_out (uio_out_b),
        .uio_oe  (uio_oe_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    bit [15:0] ram [0:65535];
    bit [15:0] hist [$];
    bit [15:0] m_addr;
    bit [15:0] m_w;
    bit [15:0] m_c;
    bit        m_valid;
    int        fr;
    int        k;
    int        hold_mode;
    bit        clr_rand;
    bit        force_clr;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h",
                     tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr  = '0;
        m_w     = '0;
        m_c     = '0;
        m_valid = 1'b0;
        fr      = 0;
        k       = 0;
        hist    = {};
        hist.push_back(16'h0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'($urandom);
        #2;
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic peek(input bit sel, input bit hi,
                        input logic [7:0] exp,
                        input string tag);
        ui_in[3] = hi;
        ui_in[2] = sel;
        #1;
        check(tag, uio_out, exp);
    endtask

    task automatic do_cycle();
        bit [3:0]  nib;
        bit        h;
        bit        clr;
        bit        sel;
        bit        hi;
        bit [15:0] rw;
        bit [15:0] s16;
        bit [7:0]  exp_uo;
        bit [7:0]  exp_uio;
        case (hold_mode)
            1:       h = (fr >= 1);
            2:       h = 1'($urandom);
            default: h = 1'b0;
        endcase
        clr = force_clr ||
              (clr_rand && $urandom_range(0, 7) == 0);
        sel = 1'($urandom);
        hi  = 1'($urandom);
        rw  = '0;
        if (fr >= 2) begin
            rw  = ram[hist[fr-2]];
            nib = rw[4*k +: 4];
        end else begin
            nib = 4'($urandom);
        end
        ui_in = {nib, hi, sel, clr, h};
        #1;
        exp_uo = {m_addr[4*k +: 4], 1'b0, m_valid, 2'(k)};
        check("uo_out", uo_out, exp_uo);
        s16 = sel ? m_c : m_w;
        exp_uio = hi ? s16[15:8] : s16[7:0];
        check("uio_out", uio_out, exp_uio);
        check("uio_oe", uio_oe, 8'hFF);
        @(posedge clk);
        #1;
        m_w[4*k +: 4] = nib;
        if (clr) begin
            m_c = '0;
        end else if (k == 3 && fr >= 2) begin
            m_c = m_c + rw;
        end
        if (k == 3) begin
            if (fr >= 2) m_valid = 1'b1;
            if (!h) m_addr = m_addr + 16'd1;
            fr++;
            hist.push_back(m_addr);
            k = 0;
        end else begin
            k++;
        end
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < 4 * n; i++) do_cycle();
    endtask

    initial begin
        bit [7:0] a8;
        for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
        ram[0] = 16'h1234;
        ram[1] = 16'hABCD;
        hold_mode = 0;
        clr_rand  = 1'b0;
        force_clr = 1'b0;

        // First frames, read path and checksum.
        do_reset();
        run_frames(3);
        peek(1'b0, 1'b0, 8'h34, "word_lo_f2");
        run_frames(1);
        peek(1'b0, 1'b1, 8'hAB, "word_hi_f3");
        peek(1'b1, 1'b0, 8'h01, "csum_lo");
        peek(1'b1, 1'b1, 8'hBE, "csum_hi");
        force_clr = 1'b1;
        do_cycle();
        force_clr = 1'b0;
        peek(1'b1, 1'b0, 8'h00, "clr_lo");
        peek(1'b1, 1'b1, 8'h00, "clr_hi");
        run_frames(2);

        // Random hold and clear.
        hold_mode = 2;
        clr_rand  = 1'b1;
        run_frames(30);

        // Hold from frame 1 onward.
        hold_mode = 1;
        clr_rand  = 1'b0;
        do_reset();
        run_frames(8);

        // Reset mid-frame, then a fresh start.
        hold_mode = 0;
        clr_rand  = 1'b1;
        do_reset();
        while (!(fr == 5 && k == 2)) do_cycle();
        do_reset();
        run_frames(5);

        // Address wrap on an 8-bit-address instance.
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int f = 0; f < 258; f++) begin
            for (int p = 0; p < 2; p++) begin
                ui_in_b = {4'($urandom), 3'($urandom), 1'b0};
                #1;
                a8 = 8'(f);
                check("wrap_addr", uo_out_b[7:4], a8[4*p +: 4]);
                check("wrap_phase", uo_out_b[1:0], 2'(p));
                check("wrap_oe", uio_oe_b, 8'hFF);
                @(posedge clk);
                #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
